reg_seq_ctrl: RTL and testbench

//  Sequencing FSM for the 4x8 register file: accepts one 10-bit instruction via valid/ready,

---
 rtl/reg_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_reg_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_seq_ctrl.sv
// reg_seq_ctrl: sequencing FSM for the 4x8 register file.
// Accepts one 10-bit instruction at a time through valid/ready, then walks it
// through READ / EXEC / WB or READ / MEM / MWB (or a single-cycle write/error
// state). All strobes are Moore decodes of the registered state and the
// latched opcode, so nothing on the outputs depends combinationally on inputs.
module reg_seq_ctrl #(
  parameter int ALU_LAT     = 1,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [9:0] instr,
  output logic [1:0] r1,
  output logic [1:0] r2,
  output logic [5:0] immediate,
  output logic       reg_r_en,
  output logic       reg_readx_en,
  output logic       reg_ready_en,
  output logic       y_is_imm,
  output logic       reg_w_en,
  output logic       reg_hi_en,
  output logic       reg_lo_en,
  output logic       reg_swap_en,
  output logic       reg_mem_w_en,
  output logic       alu_go,
  output logic       mem_req,
  input  logic       mem_ack,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // One counter serves both the EXEC latency and the MEM timeout.
  localparam int CNT_MAX = (ALU_LAT > MEM_TIMEOUT) ? ALU_LAT : MEM_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_ALU_RR = 4'd1;
  localparam logic [3:0] OP_ALU_RI = 4'd2;
  localparam logic [3:0] OP_SETHI  = 4'd3;
  localparam logic [3:0] OP_SETLO  = 4'd4;
  localparam logic [3:0] OP_MOV    = 4'd5;
  localparam logic [3:0] OP_LOAD   = 4'd6;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_NOPD = 4'd1;
  localparam logic [3:0] S_HI   = 4'd2;
  localparam logic [3:0] S_LO   = 4'd3;
  localparam logic [3:0] S_MOV  = 4'd4;
  localparam logic [3:0] S_READ = 4'd5;
  localparam logic [3:0] S_EXEC = 4'd6;
  localparam logic [3:0] S_WB   = 4'd7;
  localparam logic [3:0] S_MEM  = 4'd8;
  localparam logic [3:0] S_MWB  = 4'd9;
  localparam logic [3:0] S_ERR  = 4'd10;

  logic [3:0]    r_state;
  logic [3:0]    w_next_state;
  logic [3:0]    r_op;
  logic [1:0]    r_r1;
  logic [1:0]    r_r2;
  logic [3:0]    r_imm4;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  assign w_accept = instr_valid && (r_state == S_IDLE);

  // Next-state decode: dispatch on the opcode at accept, then step the sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (instr[9:6])
            OP_NOP:                       w_next_state = S_NOPD;
            OP_ALU_RR, OP_ALU_RI, OP_LOAD: w_next_state = S_READ;
            OP_SETHI:                     w_next_state = S_HI;
            OP_SETLO:                     w_next_state = S_LO;
            OP_MOV:                       w_next_state = S_MOV;
            default:                      w_next_state = S_ERR;
          endcase
        end
      end
      S_READ: w_next_state = (r_op == OP_LOAD) ? S_MEM : S_EXEC;
      S_EXEC: begin
        if (r_cnt == CW'(ALU_LAT - 1)) w_next_state = S_WB;
      end
      S_MEM: begin
        // A late ack on the final allowed cycle still wins over the timeout.
        if (mem_ack)                              w_next_state = S_MWB;
        else if (r_cnt == CW'(MEM_TIMEOUT - 1))   w_next_state = S_ERR;
      end
      default: w_next_state = S_IDLE;  // every terminal state returns to IDLE
    endcase
  end

  // State register and instruction field latches (fields change only on accept).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= 4'd0;
      r_r1    <= 2'd0;
      r_r2    <= 2'd0;
      r_imm4  <= 4'd0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_op   <= instr[9:6];
        r_r1   <= instr[5:4];
        r_r2   <= instr[3:2];
        r_imm4 <= instr[3:0];
      end
    end
  end

  // Cycle counter: cleared in READ so it starts at 0 on entry to EXEC or MEM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == S_READ) begin
      r_cnt <= '0;
    end else if ((r_state == S_EXEC) || (r_state == S_MEM)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign instr_ready  = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign r1           = r_r1;
  assign r2           = r_r2;
  assign immediate    = {2'b00, r_imm4};

  assign reg_r_en     = (r_state == S_READ);
  assign reg_readx_en = (r_state == S_READ) && (r_op != OP_LOAD);
  assign reg_ready_en = (r_state == S_READ) && (r_op != OP_ALU_RI);
  assign y_is_imm     = (r_state == S_READ) && (r_op == OP_ALU_RI);

  assign alu_go       = (r_state == S_EXEC) && (r_cnt == '0);
  assign mem_req      = (r_state == S_MEM);

  assign reg_w_en     = (r_state == S_WB);
  assign reg_hi_en    = (r_state == S_HI);
  assign reg_lo_en    = (r_state == S_LO);
  assign reg_swap_en  = (r_state == S_MOV);
  assign reg_mem_w_en = (r_state == S_MWB);

  assign done = (r_state == S_NOPD) || (r_state == S_HI)  || (r_state == S_LO) ||
                (r_state == S_MOV)  || (r_state == S_WB)  || (r_state == S_MWB) ||
                (r_state == S_ERR);
  assign err  = (r_state == S_ERR);

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// tb_reg_seq_ctrl: table of instructions with expected per-instruction
// signatures, pushed to a scoreboard at issue and checked when done pulses;
// plus hand sequences for ready timing and reset in the middle of a LOAD.
module tb_reg_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [9:0] instr;
  logic [1:0] r1, r2;
  logic [5:0] immediate;
  logic       reg_r_en, reg_readx_en, reg_ready_en, y_is_imm;
  logic       reg_w_en, reg_hi_en, reg_lo_en, reg_swap_en, reg_mem_w_en;
  logic       alu_go, mem_req, mem_ack, busy, done, err;

  always #5 clk = ~clk;

  reg_seq_ctrl #(.ALU_LAT(1), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .r1(r1), .r2(r2), .immediate(immediate),
    .reg_r_en(reg_r_en), .reg_readx_en(reg_readx_en), .reg_ready_en(reg_ready_en),
    .y_is_imm(y_is_imm), .reg_w_en(reg_w_en), .reg_hi_en(reg_hi_en),
    .reg_lo_en(reg_lo_en), .reg_swap_en(reg_swap_en), .reg_mem_w_en(reg_mem_w_en),
    .alu_go(alu_go), .mem_req(mem_req), .mem_ack(mem_ack), .busy(busy),
    .done(done), .err(err)
  );

  // ack: 0 = never ack, N = ack in the Nth MEM cycle. spur: hold mem_ack high
  // outside MEM. wstb = {w, hi, lo, swap, mem_w}; rd = {r_en, readx, ready, y_imm}.
  typedef struct {
    logic [3:0] op;
    logic [1:0] r1;
    logic [3:0] imm4;
    int         ack;
    logic       spur;
    int         lat;
    logic       err;
    logic [4:0] wstb;
    logic [3:0] rd;
    int         alu_cyc;
    int         mreq;
    logic [1:0] r2;
    logic [5:0] imm;
  } vec_t;

  vec_t vecs[12];
  vec_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  int   cur_ack  = 0;
  logic cur_spur = 1'b0;
  int   mem_seen = 0;

  function automatic vec_t mk(logic [3:0] op, logic [1:0] r1_i, logic [3:0] imm4, int ack,
                              logic spur, int lat, logic e, logic [4:0] wstb, logic [3:0] rd,
                              int alu_cyc, int mreq, logic [1:0] r2_i, logic [5:0] imm);
    vec_t v;
    v.op = op; v.r1 = r1_i; v.imm4 = imm4; v.ack = ack; v.spur = spur; v.lat = lat;
    v.err = e; v.wstb = wstb; v.rd = rd; v.alu_cyc = alu_cyc; v.mreq = mreq;
    v.r2 = r2_i; v.imm = imm;
    return v;
  endfunction

  function automatic logic any_out();
    return reg_r_en | reg_readx_en | reg_ready_en | y_is_imm | reg_w_en | reg_hi_en |
           reg_lo_en | reg_swap_en | reg_mem_w_en | alu_go | mem_req | done | err;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Memory model: answers mem_req in the requested MEM cycle, optionally
  // holding a spurious ack while not in MEM.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req) mem_seen++;
      else         mem_seen = 0;
      mem_ack = cur_spur || ((cur_ack != 0) && mem_req && (mem_seen == cur_ack));
    end
  end

  // Monitor: accumulate per-instruction activity, compare against scoreboard at done.
  int         m_cyc = 0;
  logic [4:0] m_w   = '0;
  logic [3:0] m_rd  = '0;
  int         m_alu = 0;
  int         m_mreq = 0;
  logic       m_err = 1'b0;
  logic [4:0] m_wv;
  vec_t       m_e;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        m_cyc = 0; m_w = '0; m_rd = '0; m_alu = 0; m_mreq = 0; m_err = 1'b0;
      end else if (busy) begin
        m_cyc++;
        m_wv = {reg_w_en, reg_hi_en, reg_lo_en, reg_swap_en, reg_mem_w_en};
        chk("one_wstb", ($countones(m_wv) <= 1) ? 1 : 0, 1);
        m_w  = m_w | m_wv;
        m_rd = m_rd | {reg_r_en, reg_readx_en, reg_ready_en, y_is_imm};
        if (alu_go) m_alu = (m_alu == 0) ? m_cyc : -1;
        if (mem_req) m_mreq++;
        m_err = m_err | err;
        if (done) begin
          chk("sb_nonempty", (sb.size() != 0) ? 1 : 0, 1);
          if (sb.size() != 0) begin
            m_e = sb.pop_front();
            $display("txn op=%0d r1=%0d r2=%0d imm=%0h lat=%0d err=%0b wstb=%b rd=%b alu=%0d mreq=%0d",
                     m_e.op, r1, r2, immediate, m_cyc, err, m_w, m_rd, m_alu, m_mreq);
            chk("latency",   m_cyc,  m_e.lat);
            chk("err_done",  err,    m_e.err);
            chk("err_any",   m_err,  m_e.err);
            chk("wstb",      m_w,    m_e.wstb);
            chk("read_stb",  m_rd,   m_e.rd);
            chk("alu_cycle", m_alu,  m_e.alu_cyc);
            chk("mem_req_n", m_mreq, m_e.mreq);
            chk("r1",        r1,     m_e.r1);
            chk("r2",        r2,     m_e.r2);
            chk("immediate", immediate, m_e.imm);
          end
          m_cyc = 0; m_w = '0; m_rd = '0; m_alu = 0; m_mreq = 0; m_err = 1'b0;
        end
      end else begin
        chk("idle_quiet", any_out(), 0);
      end
    end
  end

  // Issue one instruction; returns 1 ns after the accepting edge.
  task automatic send(input vec_t v);
    int n;
    n = 0;
    while (!instr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", instr_ready, 1);
    if (instr_ready) begin
      instr       = {v.op, v.r1, v.imm4};
      cur_ack     = v.ack;
      cur_spur    = v.spur;
      instr_valid = 1'b1;
      sb.push_back(v);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instr       = 10'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = mk(4'd3,  2'd2, 4'hA, 0,  1'b1, 1,  1'b0, 5'b01000, 4'b0000, 0, 0,  2'd2, 6'h0A);
    vecs[1]  = mk(4'd1,  2'd1, 4'hC, 0,  1'b1, 3,  1'b0, 5'b10000, 4'b1110, 2, 0,  2'd3, 6'h0C);
    vecs[2]  = mk(4'd2,  2'd0, 4'h5, 0,  1'b1, 3,  1'b0, 5'b10000, 4'b1101, 2, 0,  2'd1, 6'h05);
    vecs[3]  = mk(4'd4,  2'd3, 4'h7, 0,  1'b0, 1,  1'b0, 5'b00100, 4'b0000, 0, 0,  2'd1, 6'h07);
    vecs[4]  = mk(4'd5,  2'd1, 4'h8, 0,  1'b1, 1,  1'b0, 5'b00010, 4'b0000, 0, 0,  2'd2, 6'h08);
    vecs[5]  = mk(4'd0,  2'd0, 4'h0, 0,  1'b1, 1,  1'b0, 5'b00000, 4'b0000, 0, 0,  2'd0, 6'h00);
    vecs[6]  = mk(4'd6,  2'd2, 4'h4, 3,  1'b0, 5,  1'b0, 5'b00001, 4'b1010, 0, 3,  2'd1, 6'h04);
    vecs[7]  = mk(4'd6,  2'd1, 4'hF, 1,  1'b0, 3,  1'b0, 5'b00001, 4'b1010, 0, 1,  2'd3, 6'h0F);
    vecs[8]  = mk(4'd6,  2'd0, 4'h0, 0,  1'b0, 18, 1'b1, 5'b00000, 4'b1010, 0, 16, 2'd0, 6'h00);
    vecs[9]  = mk(4'd15, 2'd3, 4'h3, 0,  1'b1, 1,  1'b1, 5'b00000, 4'b0000, 0, 0,  2'd0, 6'h03);
    vecs[10] = mk(4'd7,  2'd2, 4'hE, 0,  1'b0, 1,  1'b1, 5'b00000, 4'b0000, 0, 0,  2'd3, 6'h0E);
    vecs[11] = mk(4'd6,  2'd3, 4'h9, 16, 1'b0, 18, 1'b0, 5'b00001, 4'b1010, 0, 16, 2'd2, 6'h09);

    // Reset state
    reset = 1'b1; instr_valid = 1'b0; instr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_outs", any_out(), 0);
    chk("rst_r1", r1, 0);
    chk("rst_r2", r2, 0);
    chk("rst_imm", immediate, 0);

    // Table-driven instructions
    foreach (vecs[i]) send(vecs[i]);
    drain();

    // SETHI: ready must stay low in the done cycle and return the cycle after
    send(vecs[0]);
    @(negedge clk);
    chk("done_cycle_ready", instr_ready, 0);
    chk("done_cycle_done", done, 1);
    @(negedge clk);
    chk("ready_after_done", instr_ready, 1);
    drain();

    // Reset while a LOAD waits in MEM
    send(vecs[8]);
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("load_mem_req", mem_req, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_outs", any_out(), 0);
    chk("midrst_r1", r1, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready", instr_ready, 1);
    chk("midrst_quiet", any_out(), 0);

    // Recovery after reset
    send(vecs[1]);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
